// File: rtl/ifu_rd_port.sv
// ifu_rd_port: fetch-stage read port; turns one-cycle read commands into single-word bus reads.
// Optional IFU_LAST_FETCH_BYPASS_EN: a repeat fetch of the last good address is served without a bus access.
module ifu_rd_port #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_rd_cmd,
    output logic [DATA_WIDTH-1:0] o_instr_dat,
    output logic                  o_busy,
    output logic                  o_err_align,
    output logic                  o_err_bus,
    output logic [ADDR_WIDTH-1:0] o_MAddr,
    output logic [2:0]            o_MCmd,
    output logic [3:0]            o_MByteEn,
    input  logic                  i_SCmdAccept,
    input  logic [DATA_WIDTH-1:0] i_SData,
    input  logic [1:0]            i_SResp
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_READ = 3'b010;

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          hit, cmd_idle, start, align_err, resp_en, resp_ok, resp_err, tmo, fail;

`ifdef IFU_LAST_FETCH_BYPASS_EN
    logic [ADDR_WIDTH-1:0] tag;
    logic                  tag_vld;

    assign hit = tag_vld && tag == i_addr;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tag     <= '0;
            tag_vld <= 1'b0;
        end else if (resp_ok) begin
            tag     <= o_MAddr;
            tag_vld <= 1'b1;
        end else if (align_err || fail) begin
            tag_vld <= 1'b0;
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_comb begin
        cmd_idle  = state == IDLE && i_rd_cmd;
        start     = cmd_idle && i_addr[1:0] == 2'b00 && !hit;
        align_err = cmd_idle && i_addr[1:0] != 2'b00;
        // a response arriving together with the accept is taken immediately
        resp_en   = state == RESP || (state == CMD && i_SCmdAccept);
        resp_ok   = resp_en && i_SResp == 2'b01;
        resp_err  = resp_en && i_SResp[1];
        tmo       = TIMEOUT_CYCLES != 0 && state != IDLE && cnt == CW'(TIMEOUT_CYCLES - 1);
        fail      = resp_err || (tmo && !resp_ok);
        state_nx  = start ? CMD :
                    (resp_ok || fail) ? IDLE :
                    (state == CMD && i_SCmdAccept) ? RESP : state;
        o_busy    = state != IDLE || start;
        o_MCmd    = state == CMD ? MCMD_READ : MCMD_IDLE;
        o_MByteEn = state == CMD ? 4'hF : 4'h0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= '0;
            o_instr_dat <= '0;
            o_err_align <= 1'b0;
            o_err_bus   <= 1'b0;
            o_MAddr     <= '0;
        end else begin
            cnt <= start ? '0 : (state != IDLE ? cnt + 1'b1 : cnt);
            if (start) begin
                o_MAddr     <= i_addr;
                o_err_align <= 1'b0;
                o_err_bus   <= 1'b0;
            end
            if (align_err) begin
                o_err_align <= 1'b1;
                o_err_bus   <= 1'b0;
                o_instr_dat <= '0;
            end
            if (resp_ok) begin
                o_instr_dat <= i_SData;
            end else if (fail) begin
                o_err_bus   <= 1'b1;
                o_instr_dat <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ifu_rd_port.sv
// tb_ifu_rd_port: scoreboard bench; driver queues expected results, negedge monitor checks each completion.
module tb_ifu_rd_port;
    logic        clk = 1'b0, nrst = 1'b0;
    logic [31:0] i_addr = '0, i_SData = '0;
    logic        i_rd_cmd = 1'b0, i_SCmdAccept = 1'b0;
    logic [1:0]  i_SResp = 2'b00;
    logic [31:0] o_instr_dat, o_MAddr;
    logic        o_busy, o_err_align, o_err_bus;
    logic [2:0]  o_MCmd;
    logic [3:0]  o_MByteEn;
    int          checks = 0, failures = 0;

    typedef struct {
        logic [31:0] addr, dat;
        logic        ea, eb;
        int          busy_cyc, rd_cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    logic pend = 1'b0, bad = 1'b0;
    int   bc = 0, rc = 0;

    ifu_rd_port #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .nrst(nrst), .i_addr(i_addr), .i_rd_cmd(i_rd_cmd),
        .o_instr_dat(o_instr_dat), .o_busy(o_busy), .o_err_align(o_err_align),
        .o_err_bus(o_err_bus), .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MByteEn(o_MByteEn),
        .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: counts busy/READ cycles of the current op and checks the result when busy drops
    always @(negedge clk) begin
        if (!nrst) begin
            pend = 1'b0; bad = 1'b0; bc = 0; rc = 0;
        end else begin
            if (o_busy) bc++;
            if (o_MCmd == 3'b010) begin
                rc++;
                if (o_MByteEn != 4'hF || (q.size() > 0 && o_MAddr != q[0].addr)) bad = 1'b1;
            end else if (o_MCmd != 3'b000 || o_MByteEn != 4'h0) bad = 1'b1;
            if (pend && !o_busy) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL sb_empty: completion at %0t with no expected entry", $time);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("dat@%h", e.addr), o_instr_dat, e.dat);
                    chk($sformatf("err_align@%h", e.addr), o_err_align, e.ea);
                    chk($sformatf("err_bus@%h", e.addr), o_err_bus, e.eb);
                    chk($sformatf("busy_cycles@%h", e.addr), bc, e.busy_cyc);
                    chk($sformatf("read_cycles@%h", e.addr), rc, e.rd_cyc);
                    chk($sformatf("bus_signals@%h", e.addr), bad, 0);
                end
                pend = 1'b0; bad = 1'b0; bc = 0; rc = 0;
            end
            if (i_rd_cmd || o_busy) pend = 1'b1;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic expect_op(input logic [31:0] a, input logic [31:0] d, input logic ea, input logic eb,
                             input int bcy, input int rcy);
        exp_t x;
        x.addr = a; x.dat = d; x.ea = ea; x.eb = eb; x.busy_cyc = bcy; x.rd_cyc = rcy;
        q.push_back(x);
    endtask

    task automatic pulse(input logic [31:0] a);
        step(); i_addr = a; i_rd_cmd = 1'b1;
        step(); i_rd_cmd = 1'b0;
    endtask

    // rsp_wait < 0 puts the response in the accept cycle
    task automatic bus_rd(input logic [31:0] a, input int acc_wait, input int rsp_wait,
                          input logic [1:0] rsp, input logic [31:0] d);
        pulse(a);
        repeat (acc_wait) step();
        i_SCmdAccept = 1'b1;
        if (rsp_wait < 0) begin i_SResp = rsp; i_SData = d; end
        step(); i_SCmdAccept = 1'b0; i_SResp = 2'b00;
        if (rsp_wait >= 0) begin
            repeat (rsp_wait) step();
            i_SResp = rsp; i_SData = d;
            step(); i_SResp = 2'b00;
        end
        i_SData = '0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 40) begin step(); n++; end
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL wait_done: %0d results outstanding after 40 cycles", q.size());
            q.delete();
        end
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(); step();
        chk("rst_instr", o_instr_dat, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_err_align", o_err_align, 0);
        chk("rst_err_bus", o_err_bus, 0);
        chk("rst_maddr", o_MAddr, 0);
        chk("rst_mcmd", o_MCmd, 0);
        chk("rst_mbyteen", o_MByteEn, 0);
        nrst = 1'b1; step();

        expect_op(32'h100, 32'h24080005, 0, 0, 3, 1);
        bus_rd(32'h100, 0, 0, 2'b01, 32'h24080005); wait_done();

        expect_op(32'h102, 32'h0, 1, 0, 0, 0);
        pulse(32'h102); wait_done();

        expect_op(32'h200, 32'h0, 0, 1, 8, 6);
        bus_rd(32'h200, 5, 0, 2'b11, 32'hAAAA5555); wait_done();

        expect_op(32'hFFFFFFFC, 32'hDEADBEEF, 0, 0, 6, 3);
        bus_rd(32'hFFFFFFFC, 2, 1, 2'b01, 32'hDEADBEEF); wait_done();

        expect_op(32'h240, 32'h0, 0, 1, 4, 2);
        bus_rd(32'h240, 1, 0, 2'b10, 32'h55555555); wait_done();

        expect_op(32'h180, 32'h0, 0, 1, 9, 1);
        bus_rd(32'h180, 0, 12, 2'b01, 32'h13572468); wait_done();
        chk("timeout_late_dat", o_instr_dat, 0);
        chk("timeout_late_err", o_err_bus, 1);
        chk("timeout_late_busy", o_busy, 0);

        expect_op(32'h400, 32'h11112222, 0, 0, 2, 1);
        bus_rd(32'h400, 0, -1, 2'b01, 32'h11112222); wait_done();

        pulse(32'h500);
        i_SCmdAccept = 1'b1; step(); i_SCmdAccept = 1'b0;
        #2 nrst = 1'b0; #1;
        chk("midrst_instr", o_instr_dat, 0);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_maddr", o_MAddr, 0);
        chk("midrst_mcmd", o_MCmd, 0);
        chk("midrst_mbyteen", o_MByteEn, 0);
        step(); step();
        nrst = 1'b1; i_SResp = 2'b01; i_SData = 32'hBAD0BAD0;
        step(); i_SResp = 2'b00; i_SData = '0; step();
        chk("midrst_late_dat", o_instr_dat, 0);

        expect_op(32'h300, 32'h0BADCAFE, 0, 0, 3, 1);
        bus_rd(32'h300, 0, 0, 2'b01, 32'h0BADCAFE); wait_done();

`ifdef IFU_LAST_FETCH_BYPASS_EN
        expect_op(32'h100, 32'h8C220004, 0, 0, 3, 1);
        bus_rd(32'h100, 0, 0, 2'b01, 32'h8C220004); wait_done();
        expect_op(32'h100, 32'h8C220004, 0, 0, 0, 0);
        pulse(32'h100); wait_done();
        expect_op(32'h104, 32'h00221820, 0, 0, 3, 1);
        bus_rd(32'h104, 0, 0, 2'b01, 32'h00221820); wait_done();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
